// File: rtl/mmio_console_pkg.sv
// Shared constants for the memory-mapped console: register offsets,
// STATUS bit positions, interrupt codes and the UART transmitter states.
package mmio_console_pkg;

    // Register offsets within the 32-byte window (bus_address[4:0])
    localparam logic [4:0] TX_OFF   = 5'h00;
    localparam logic [4:0] STAT_OFF = 5'h08;
    localparam logic [4:0] RX_OFF   = 5'h10;

    // STATUS/CTRL bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_HOLD     = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_TX_DROP     = 4;
    localparam int ST_RX_IE       = 8;
    localparam int ST_RX_COUNT    = 9;   // rx_count occupies [11:9]

    // Interrupt vector codes presented to the core
    localparam logic [3:0] IRQ_NONE    = 4'd0;
    localparam logic [3:0] IRQ_CONSOLE = 4'd1;

    // 8N1 transmitter frame phases
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_console_if.sv
// Single-cycle 64-bit CPU bus as seen by the console: the core is the
// master, the console responds with combinational read data.
interface mmio_console_if;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;

    modport master (
        output bus_address,
        output bus_write_data,
        output bus_write_enable,
        output bus_read_enable,
        input  bus_read_data
    );

    modport slave (
        input  bus_address,
        input  bus_write_data,
        input  bus_write_enable,
        input  bus_read_enable,
        output bus_read_data
    );
endinterface

// File: rtl/mmio_console_uart_tx_8n1.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each held
// for CLKS_PER_BIT cycles. A pending byte is taken either from idle or at the
// very end of a stop bit, so queued frames go out with no idle gap.
module uart_tx_8n1
    import mmio_console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       accept_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    // Next-state, baud/bit counting and line level for the frame in flight
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        accept_o = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    accept_o = 1'b1;
                    shift_d  = data_i;
                    baud_d   = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (start_i) begin
                        accept_o = 1'b1;
                        shift_d  = data_i;
                        state_d  = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level is registered from the upcoming state so it never glitches
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Frame state registers; reset abandons any frame and idles the line high
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign busy_o = (state_q != TX_IDLE);
    assign tx_o   = tx_q;

endmodule

// File: rtl/mmio_console.sv
// Console responder on the 64-bit CPU bus: TX holding register feeding an
// 8N1 serialiser, keyboard receive FIFO, STATUS/CTRL register and an
// acknowledged interrupt request towards the core.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'h8000_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    mmio_console_if.slave       bus,
    input  logic [7:0]          kbd_data,
    input  logic                kbd_valid,
    output logic                uart_tx,
    output logic [3:0]          interrupt_vector,
    input  logic                interrupt_ack
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // RX FIFO storage and bookkeeping
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Control / status state
    logic       hold_full_q, hold_full_d;
    logic [7:0] hold_byte_q, hold_byte_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_drop_q, tx_drop_d;
    logic       rx_ie_q, rx_ie_d;
    logic       in_service_q, in_service_d;

    // Decode and handshake terms
    logic        in_window;
    logic [4:0]  offset;
    logic        rd_hit, wr_hit;
    logic        rx_read, stat_write, tx_write;
    logic        fifo_empty, fifo_full;
    logic        pop, push, overrun_evt;
    logic        irq_req, ack_ok;
    logic        tx_accept, tx_busy;
    logic [63:0] status;
    logic        unused_wdata;

    assign in_window  = (bus.bus_address[63:5] == BASE_ADDR[63:5]);
    assign offset     = bus.bus_address[4:0];
    assign rd_hit     = bus.bus_read_enable & in_window;
    assign wr_hit     = bus.bus_write_enable & in_window;
    assign rx_read    = rd_hit & (offset == RX_OFF);
    assign stat_write = wr_hit & (offset == STAT_OFF);
    assign tx_write   = wr_hit & (offset == TX_OFF);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

    // A pop on the same edge frees the slot a full FIFO would otherwise refuse
    assign pop         = rx_read & ~fifo_empty;
    assign push        = kbd_valid & (~fifo_full | pop);
    assign overrun_evt = kbd_valid & fifo_full & ~pop;

    assign irq_req          = ~fifo_empty & rx_ie_q & ~in_service_q;
    assign interrupt_vector = irq_req ? IRQ_CONSOLE : IRQ_NONE;
    assign ack_ok           = interrupt_ack & irq_req;

    // Only the low byte and the CTRL bits of write data carry meaning
    assign unused_wdata = ^bus.bus_write_data[63:9];

    // STATUS word assembled from live state
    always_comb begin
        status                             = '0;
        status[ST_RX_NONEMPTY]             = ~fifo_empty;
        status[ST_TX_HOLD]                 = hold_full_q;
        status[ST_TX_BUSY]                 = tx_busy;
        status[ST_RX_OVERRUN]              = rx_overrun_q;
        status[ST_TX_DROP]                 = tx_drop_q;
        status[ST_RX_IE]                   = rx_ie_q;
        status[ST_RX_COUNT +: 3]           = 3'(count_q);
    end

    // Combinational read mux; TX_DATA reads alias STATUS
    always_comb begin
        bus.bus_read_data = '0;
        if (rd_hit) begin
            case (offset)
                TX_OFF, STAT_OFF: bus.bus_read_data = status;
                RX_OFF: begin
                    if (!fifo_empty) begin
                        bus.bus_read_data = {56'd0, fifo_mem[rd_ptr_q]};
                    end
                end
                default: bus.bus_read_data = '0;
            endcase
        end
    end

    // Next-state for FIFO pointers, holding register, flags and interrupt service
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        hold_full_d  = hold_full_q;
        hold_byte_d  = hold_byte_q;
        tx_drop_d    = tx_drop_q;
        rx_ie_d      = rx_ie_q;
        rx_overrun_d = rx_overrun_q;
        in_service_d = in_service_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags: write-1-to-clear, but a fresh event on the same edge wins
        if (stat_write) begin
            rx_ie_d = bus.bus_write_data[ST_RX_IE];
            if (bus.bus_write_data[ST_RX_OVERRUN]) rx_overrun_d = 1'b0;
            if (bus.bus_write_data[ST_TX_DROP])    tx_drop_d    = 1'b0;
        end
        if (overrun_evt) rx_overrun_d = 1'b1;

        // The serialiser empties the holding register when it takes the byte;
        // a write sees the register as it was before this edge
        if (tx_accept) hold_full_d = 1'b0;
        if (tx_write) begin
            if (hold_full_q) begin
                tx_drop_d = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_byte_d = bus.bus_write_data[7:0];
            end
        end

        if (rx_read) begin
            in_service_d = 1'b0;
        end else if (ack_ok) begin
            in_service_d = 1'b1;
        end
    end

    // Control and FIFO bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_full_q  <= 1'b0;
            hold_byte_q  <= 8'd0;
            tx_drop_q    <= 1'b0;
            rx_ie_q      <= 1'b1;
            rx_overrun_q <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_full_q  <= hold_full_d;
            hold_byte_q  <= hold_byte_d;
            tx_drop_q    <= tx_drop_d;
            rx_ie_q      <= rx_ie_d;
            rx_overrun_q <= rx_overrun_d;
            in_service_q <= in_service_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= kbd_data;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .start_i  (hold_full_q),
        .data_i   (hold_byte_q),
        .accept_o (tx_accept),
        .busy_o   (tx_busy),
        .tx_o     (uart_tx)
    );

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: a queue-based model of the console (RX byte queue,
// expected serial line as a per-cycle bit queue) checked every cycle, plus
// directed transactions with hand-computed literal expectations.
module tb_mmio_console;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] A_TX  = 64'h8000_0000;
    localparam logic [63:0] A_ST  = 64'h8000_0008;
    localparam logic [63:0] A_RX  = 64'h8000_0010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] kbd_data = 8'd0;
    logic       kbd_valid = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic       uart_tx;
    logic [3:0] interrupt_vector;

    mmio_console_if bus();

    mmio_console #(
        .BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid),
        .uart_tx(uart_tx), .interrupt_vector(interrupt_vector),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned rxq[$];
    bit           line_q[$];
    bit           m_ovr, m_drop, m_ie, m_insvc, m_hold, m_valid;
    logic [7:0]   m_hold_byte;

    function automatic logic [63:0] m_status();
        logic [63:0] s;
        s     = '0;
        s[0]  = (rxq.size() != 0);
        s[1]  = m_hold;
        s[2]  = (line_q.size() != 0);
        s[3]  = m_ovr;
        s[4]  = m_drop;
        s[8]  = m_ie;
        s[11:9] = 3'(rxq.size());
        return s;
    endfunction

    function automatic logic [3:0] m_vector();
        return (rxq.size() != 0 && m_ie && !m_insvc) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [63:0] m_read();
        if (!bus.bus_read_enable || bus.bus_address[63:5] != BASE[63:5]) return 64'd0;
        case (bus.bus_address[4:0])
            5'h00, 5'h08: return m_status();
            5'h10:        return (rxq.size() != 0) ? {56'd0, rxq[0]} : 64'd0;
            default:      return 64'd0;
        endcase
    endfunction

    // Model update: applies the inputs seen at each rising edge
    initial begin
        logic        hit, wr, rd, hold_pre;
        logic [4:0]  off;
        logic [3:0]  vec_pre;
        logic [63:0] wd;
        logic [9:0]  fr;
        m_valid = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                rxq.delete(); line_q.delete();
                m_ovr = 0; m_drop = 0; m_ie = 1; m_insvc = 0; m_hold = 0;
                m_hold_byte = 8'd0; m_valid = 1;
            end else if (m_valid) begin
                hit = (bus.bus_address[63:5] == BASE[63:5]);
                off = bus.bus_address[4:0];
                wr  = bus.bus_write_enable && hit;
                rd  = bus.bus_read_enable && hit;
                wd  = bus.bus_write_data;
                vec_pre  = m_vector();
                hold_pre = m_hold;
                if (rd && off == 5'h10) m_insvc = 0;
                else if (interrupt_ack && vec_pre != 0) m_insvc = 1;
                if (wr && off == 5'h08) begin
                    m_ie = wd[8];
                    if (wd[3]) m_ovr = 0;
                    if (wd[4]) m_drop = 0;
                end
                if (rd && off == 5'h10 && rxq.size() != 0) void'(rxq.pop_front());
                if (kbd_valid) begin
                    if (rxq.size() < DEPTH) rxq.push_back(kbd_data);
                    else m_ovr = 1;
                end
                if (line_q.size() != 0) void'(line_q.pop_front());
                if (line_q.size() == 0 && hold_pre) begin
                    fr = {1'b1, m_hold_byte, 1'b0};
                    for (int p = 0; p < 10; p++)
                        for (int k = 0; k < CPB; k++) line_q.push_back(fr[p]);
                    m_hold = 0;
                end
                if (wr && off == 5'h00) begin
                    if (hold_pre) m_drop = 1;
                    else begin m_hold = 1; m_hold_byte = wd[7:0]; end
                end
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                n_cmp++;
                if (uart_tx !== ((line_q.size() == 0) ? 1'b1 : line_q[0])) begin
                    n_bad++;
                    $display("FAIL model_uart_tx: got %b at %0t", uart_tx, $time);
                end
                n_cmp++;
                if (interrupt_vector !== m_vector()) begin
                    n_bad++;
                    $display("FAIL model_vector: got %0d, expected %0d at %0t",
                             interrupt_vector, m_vector(), $time);
                end
                n_cmp++;
                if (bus.bus_read_data !== m_read()) begin
                    n_bad++;
                    $display("FAIL model_read_data: got %h, expected %h at %0t",
                             bus.bus_read_data, m_read(), $time);
                end
            end
        end
    end

    // ---------------- stimulus helpers (start/end just after a rising edge) ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_read(input logic [63:0] addr, input logic [63:0] exp, input string name);
        bus.bus_address = addr; bus.bus_read_enable = 1'b1;
        @(negedge clk);
        chk(name, bus.bus_read_data, exp);
        @(posedge clk); #1;
        bus.bus_read_enable = 1'b0; bus.bus_address = 64'd0;
    endtask

    task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
        bus.bus_address = addr; bus.bus_write_data = data; bus.bus_write_enable = 1'b1;
        $display("write %h <= %h", addr, data);
        @(posedge clk); #1;
        bus.bus_write_enable = 1'b0; bus.bus_address = 64'd0; bus.bus_write_data = 64'd0;
    endtask

    task automatic kbd(input logic [7:0] b);
        kbd_data = b; kbd_valid = 1'b1;
        $display("kbd push %h", b);
        @(posedge clk); #1;
        kbd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [9:0] frame41;
        bus.bus_address = 64'd0; bus.bus_write_data = 64'd0;
        bus.bus_write_enable = 1'b0; bus.bus_read_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("reset_uart_tx", {63'd0, uart_tx}, 64'd1);
        chk("reset_vector", {60'd0, interrupt_vector}, 64'd0);
        bus_read(A_ST, 64'h100, "reset_status");

        // Single frame of 0x41: start, 1,0,0,0,0,0,1,0, stop
        frame41 = 10'b1_0100_0001_0;
        bus_write(A_TX, 64'h41);
        bus_read(A_ST, 64'h102, "tx_hold_pending");
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 1) chk($sformatf("tx41_bit%0d", c / 4), {63'd0, uart_tx}, {63'd0, frame41[c / 4]});
            bus_read(A_ST, 64'h104, $sformatf("tx41_busy_c%0d", c));
        end
        bus_read(A_ST, 64'h100, "tx41_done");

        // Interrupt handshake with two keyboard bytes
        kbd(8'h1C);
        chk("irq_after_push", {60'd0, interrupt_vector}, 64'd1);
        kbd(8'h32);
        interrupt_ack = 1'b1; idle(1); interrupt_ack = 1'b0;
        chk("irq_after_ack", {60'd0, interrupt_vector}, 64'd0);
        bus_read(A_RX, 64'h1C, "rx_first");
        chk("irq_after_read1", {60'd0, interrupt_vector}, 64'd1);
        bus_read(A_RX, 64'h32, "rx_second");
        chk("irq_after_read2", {60'd0, interrupt_vector}, 64'd0);

        // Overrun: five bytes into four entries
        for (int i = 0; i < 5; i++) kbd(8'hA0 + 8'(i));
        bus_read(A_ST, 64'h909, "overrun_status");
        bus_write(A_ST, 64'h8);
        bus_read(A_ST, 64'h801, "overrun_cleared_ie_off");
        chk("irq_ie_off", {60'd0, interrupt_vector}, 64'd0);
        bus_write(A_ST, 64'h100);
        chk("irq_ie_on", {60'd0, interrupt_vector}, 64'd1);

        // Push + pop on a full FIFO
        kbd_data = 8'hB0; kbd_valid = 1'b1;
        bus_read(A_RX, 64'hA0, "full_pushpop_read");
        kbd_valid = 1'b0;
        bus_read(A_ST, 64'h901, "full_pushpop_status");
        bus_read(A_RX, 64'hA1, "drain_a1");
        bus_read(A_RX, 64'hA2, "drain_a2");
        bus_read(A_RX, 64'hA3, "drain_a3");
        bus_read(A_RX, 64'hB0, "drain_b0");
        bus_read(A_RX, 64'h0, "empty_read");

        // Push + pop on an empty FIFO, then unmapped reads
        kbd_data = 8'hC5; kbd_valid = 1'b1;
        bus_read(A_RX, 64'h0, "empty_pushpop_read");
        kbd_valid = 1'b0;
        bus_read(A_ST, 64'h301, "empty_pushpop_status");
        bus_read(64'h9000_0010, 64'h0, "out_of_window_read");
        bus_read(64'h8000_0018, 64'h0, "unmapped_offset_read");
        bus_read(A_RX, 64'hC5, "rx_c5");

        // Back-to-back frames and a dropped third byte
        bus_write(A_TX, 64'h55);
        idle(1);
        bus_write(A_TX, 64'hA5);
        bus_write(A_TX, 64'hFF);
        bus_read(A_ST, 64'h116, "tx_drop_status");
        idle(36);
        chk("b2b_stop_bit", {63'd0, uart_tx}, 64'd1);
        idle(1);
        chk("b2b_next_start", {63'd0, uart_tx}, 64'd0);
        idle(40);
        chk("b2b_line_idle", {63'd0, uart_tx}, 64'd1);
        bus_read(A_ST, 64'h110, "b2b_done_status");
        bus_write(A_ST, 64'h110);
        bus_read(A_ST, 64'h100, "drop_cleared");

        // Reset in the middle of a frame with data in the FIFO
        bus_write(A_TX, 64'h00);
        idle(6);
        kbd(8'h77);
        reset = 1'b1; idle(1);
        chk("midframe_reset_tx", {63'd0, uart_tx}, 64'd1);
        reset = 1'b0;
        chk("midframe_reset_vector", {60'd0, interrupt_vector}, 64'd0);
        bus_read(A_ST, 64'h100, "midframe_reset_status");
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
